// File: rtl/ram_stream_reader_pkg.sv
// Shared state encoding for the RAM stream reader.
// Imported by the reader top and its skid buffer.
package ram_stream_reader_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/ram_stream_skid.sv
// Two-entry FIFO that holds RAM read data until the
// stream consumer accepts it; head is presented directly.
module ram_stream_skid
  import ram_stream_reader_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        count
);

  logic [DWIDTH-1:0] head_q, head_d;
  logic [DWIDTH-1:0] tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pop;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign count     = cnt_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({in_valid, pop})
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = in_data;
        end else begin
          tail_d = in_data;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        // simultaneous push/pop keeps occupancy
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = in_data;
        end else begin
          head_d = in_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a burst of words from a synchronous-read RAM.
// Define RAM_STREAM_READER_WRAP_EN to wrap addresses at DEPTH.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   len,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] ram_addr,
  input  logic [DWIDTH-1:0] ram_q,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [AWIDTH-1:0] A_ONE  = AWIDTH'(1);
  localparam logic [AWIDTH:0]   L_ONE  = (AWIDTH+1)'(1);
  localparam logic [AWIDTH:0]   L_MAX  = (AWIDTH+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d, addr_inc;
  logic [AWIDTH:0]   rem_q, rem_d, len_clip;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  logic [1:0]        count;
  logic [2:0]        occ;
  logic              pop;

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign ram_addr = addr_q;
  assign pop      = out_valid & out_ready;
  assign len_clip = (len > L_MAX) ? L_MAX : len;

  // slots committed after this edge's transfer
  assign occ = 3'(count) + 3'(inflight_q) - 3'(pop);

`ifdef RAM_STREAM_READER_WRAP_EN
  assign addr_inc = (addr_q == AWIDTH'(DEPTH - 1)) ?
                    '0 : addr_q + A_ONE;
`else
  assign addr_inc = addr_q + A_ONE;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    inflight_d = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            addr_d  = base_addr;
            rem_d   = len_clip;
          end
        end
      end
      RUN: begin
        if (occ < 3'd2) begin
          inflight_d = 1'b1;
          addr_d     = addr_inc;
          rem_d      = rem_q - L_ONE;
          if (rem_q == L_ONE) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!inflight_q &&
            (count == 2'd0 ||
             (count == 2'd1 && pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  ram_stream_skid #(
    .DWIDTH(DWIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (ram_q),
    .in_valid (inflight_q),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a
// synchronous RAM model holding RAM[i] = i + 0x10.
module tb_ram_stream_reader;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DP = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  logic [DW-1:0] mem [256];

  int total = 0;
  int bad   = 0;

  logic [7:0] words [$];
  int issued [$];
  int first_valid, last_valid, valid_cycles;
  int done_cnt, done_cyc, busy_cycles;
  int max_out, stall_bad;

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_addr];

  ram_stream_reader #(
    .DWIDTH(DW),
    .AWIDTH(AW),
    .DEPTH (DP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .ram_addr (ram_addr),
    .ram_q    (ram_q),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Runs one burst and records what the DUT did.
  // pat 0: ready always 1; pat 1: ready 1,0,0,1 repeating.
  // inj > 0: pulse a second start in that cycle.
  task automatic collect(input int b, input int l,
                         input int pat, input int inj,
                         input int ncyc);
    logic          p_busy, p_valid, p_ready;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    int            outst;
    words.delete();
    issued.delete();
    first_valid  = -1;
    last_valid   = -1;
    valid_cycles = 0;
    done_cnt     = 0;
    done_cyc     = -1;
    busy_cycles  = 0;
    max_out      = 0;
    stall_bad    = 0;
    p_busy  = busy;
    p_addr  = ram_addr;
    p_valid = out_valid;
    p_data  = out_data;
    p_ready = 1'b1;
    base_addr = AW'(b);
    len       = (AW+1)'(l);
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (p_busy && ram_addr != p_addr) issued.push_back(int'(p_addr));
      outst = issued.size() - words.size();
      if (outst > max_out) max_out = outst;
      if (p_valid && !p_ready && (!out_valid || out_data != p_data))
        stall_bad++;
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++;
        done_cyc = k;
      end
      if (pat == 1) out_ready = ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
      else out_ready = 1'b1;
      if (out_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = k;
        last_valid = k;
      end
      if (out_valid && out_ready) words.push_back(out_data);
      p_busy  = busy;
      p_addr  = ram_addr;
      p_valid = out_valid;
      p_data  = out_data;
      p_ready = out_ready;
      if (k == inj) begin
        start     = 1'b1;
        base_addr = AW'(100);
        len       = (AW+1)'(3);
      end else begin
        start = 1'b0;
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    base_addr = '0;
    len       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy: got %0b want 0", busy);
    end
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL reset_done: got %0b want 0", done);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %0b want 0", out_valid);
    end
    total++;
    if (out_data !== 8'h00) begin
      bad++; $display("FAIL reset_data: got %0h want 0", out_data);
    end
    total++;
    if (ram_addr !== 8'h00) begin
      bad++; $display("FAIL reset_addr: got %0d want 0", ram_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_burst;
    int got;
    collect(4, 5, 0, 0, 14);
    total++;
    if (words.size() != 5) begin
      bad++; $display("FAIL burst_count: got %0d want 5", words.size());
    end
    for (int i = 0; i < 5; i++) begin
      got = (i < words.size()) ? int'(words[i]) : -1;
      total++;
      if (got != 8'h14 + i) begin
        bad++; $display("FAIL burst_word%0d: got %0h want %0h", i, got, 8'h14 + i);
      end
    end
    for (int i = 0; i < 5; i++) begin
      got = (i < issued.size()) ? issued[i] : -1;
      total++;
      if (got != 4 + i) begin
        bad++; $display("FAIL burst_addr%0d: got %0d want %0d", i, got, 4 + i);
      end
    end
    total++;
    if (first_valid != 3) begin
      bad++; $display("FAIL burst_latency: got %0d want 3", first_valid);
    end
    total++;
    if (valid_cycles != 5 || last_valid != 7) begin
      bad++; $display("FAIL burst_nobubble: got %0d cycles last %0d want 5 last 7",
                      valid_cycles, last_valid);
    end
    total++;
    if (done_cnt != 1 || done_cyc != 8) begin
      bad++; $display("FAIL burst_done: got %0d pulses at %0d want 1 at 8",
                      done_cnt, done_cyc);
    end
  endtask

  task automatic test_backpressure;
    int got;
    collect(4, 5, 1, 0, 40);
    total++;
    if (words.size() != 5) begin
      bad++; $display("FAIL bp_count: got %0d want 5", words.size());
    end
    for (int i = 0; i < 5; i++) begin
      got = (i < words.size()) ? int'(words[i]) : -1;
      total++;
      if (got != 8'h14 + i) begin
        bad++; $display("FAIL bp_word%0d: got %0h want %0h", i, got, 8'h14 + i);
      end
    end
    total++;
    if (stall_bad != 0) begin
      bad++; $display("FAIL bp_stable: got %0d changes want 0", stall_bad);
    end
    total++;
    if (max_out > 2) begin
      bad++; $display("FAIL bp_outstanding: got %0d want <=2", max_out);
    end
    total++;
    if (issued.size() != 5) begin
      bad++; $display("FAIL bp_issues: got %0d want 5", issued.size());
    end
    total++;
    if (done_cnt != 1) begin
      bad++; $display("FAIL bp_done: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_zero_len;
    collect(50, 0, 0, 0, 6);
    total++;
    if (valid_cycles != 0) begin
      bad++; $display("FAIL zero_valid: got %0d want 0", valid_cycles);
    end
    total++;
    if (done_cnt != 1 || done_cyc != 1) begin
      bad++; $display("FAIL zero_done: got %0d pulses at %0d want 1 at 1",
                      done_cnt, done_cyc);
    end
    total++;
    if (busy_cycles != 0) begin
      bad++; $display("FAIL zero_busy: got %0d want 0", busy_cycles);
    end
  endtask

  task automatic test_wrap;
    int exp_a [4];
    int got;
`ifdef RAM_STREAM_READER_WRAP_EN
    exp_a = '{198, 199, 0, 1};
`else
    exp_a = '{198, 199, 200, 201};
`endif
    collect(198, 4, 0, 0, 14);
    for (int i = 0; i < 4; i++) begin
      got = (i < issued.size()) ? issued[i] : -1;
      total++;
      if (got != exp_a[i]) begin
        bad++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, got, exp_a[i]);
      end
      got = (i < words.size()) ? int'(words[i]) : -1;
      total++;
      if (got != ((exp_a[i] + 16) % 256)) begin
        bad++; $display("FAIL wrap_word%0d: got %0h want %0h",
                        i, got, (exp_a[i] + 16) % 256);
      end
    end
    total++;
    if (done_cnt != 1) begin
      bad++; $display("FAIL wrap_done: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int n, k, got, seen;
    base_addr = '0;
    len       = 9'd8;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    k = 0;
    while (n < 2 && k < 20) begin
      @(negedge clk);
      k++;
      if (out_valid && out_ready) n++;
    end
    total++;
    if (n < 2) begin
      bad++; $display("FAIL rmid_timeout: got %0d words want 2", n);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, out_valid} !== 3'b000 ||
        out_data !== 8'h00 || ram_addr !== 8'h00) begin
      bad++; $display("FAIL rmid_clear: got b%0b d%0b v%0b q%0h a%0d want all 0",
                      busy, done, out_valid, out_data, ram_addr);
    end
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || out_valid || busy) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL rmid_quiet: got %0d active cycles want 0", seen);
    end
    collect(10, 3, 0, 0, 12);
    for (int i = 0; i < 3; i++) begin
      got = (i < words.size()) ? int'(words[i]) : -1;
      total++;
      if (got != 8'h1A + i) begin
        bad++; $display("FAIL rmid_word%0d: got %0h want %0h", i, got, 8'h1A + i);
      end
    end
    total++;
    if (words.size() != 3 || done_cnt != 1) begin
      bad++; $display("FAIL rmid_after: got %0d words %0d done want 3 1",
                      words.size(), done_cnt);
    end
  endtask

  task automatic test_start_busy;
    int got;
    collect(20, 6, 0, 2, 20);
    total++;
    if (words.size() != 6) begin
      bad++; $display("FAIL busy_count: got %0d want 6", words.size());
    end
    for (int i = 0; i < 6; i++) begin
      got = (i < words.size()) ? int'(words[i]) : -1;
      total++;
      if (got != 8'h24 + i) begin
        bad++; $display("FAIL busy_word%0d: got %0h want %0h", i, got, 8'h24 + i);
      end
    end
    total++;
    if (issued.size() != 6 || done_cnt != 1) begin
      bad++; $display("FAIL busy_issue: got %0d issues %0d done want 6 1",
                      issued.size(), done_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
    test_reset();
    test_burst();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_reset_mid();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
